user_lock_arbiter: RTL

Arbitrates ownership of a single 8-bit user-locked register among four requesters, one per 2-bit user ID. A requester acquires an exclusive lock through round-robin arbitration, writes while it holds the lock, and releases it explicitly or by inactivity timeout. The privileged ADMIN_ID may always write. The block sits in front of the user-locked register datapath and replaces per-writer ID gating with a sequenced, shareable lock.

---
 rtl/user_lock_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/user_lock_arbiter.sv
// user_lock_arbiter: round-robin exclusive write lock with idle timeout and an always-allowed admin writer.
module user_lock_arbiter #(
  parameter int          TIMEOUT   = 16,
  parameter logic [1:0]  ADMIN_ID  = 2'h2,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  lock_req,
  input  logic [3:0]  unlock,
  input  logic [3:0]  wr_en,
  input  logic [31:0] wr_data,
  output logic [3:0]  lock_gnt,
  output logic [1:0]  owner_id,
  output logic        locked,
  output logic [7:0]  data_out,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        timeout
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state, state_n;
  logic [1:0] owner_n, rr_ptr, rr_n, pick;
  logic [7:0] cnt, cnt_n, data_n;
  logic [3:0] acc_mask;
  logic       to_n, admin_wr, own_acc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_id <= 2'd0;
      rr_ptr   <= 2'd3;
      cnt      <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      owner_id <= owner_n;
      rr_ptr   <= rr_n;
      cnt      <= cnt_n;
      timeout  <= to_n;
    end
  end
  // Lowest offset from rr_ptr+1 wins; offset 4 wraps to rr_ptr itself, searched last.
  always_comb begin
    pick = rr_ptr;
    for (int k = 4; k >= 1; k--)
      if (lock_req[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
  end
  // An admin write from a different user shadows the owner write, so it neither lands nor refreshes the lock.
  assign admin_wr = wr_en[ADMIN_ID];
  assign own_acc  = state == OWNED && wr_en[owner_id] && (owner_id == ADMIN_ID || !admin_wr);
  assign acc_mask = ({3'b0, admin_wr} << ADMIN_ID) | ({3'b0, own_acc} << owner_id);
  assign data_n   = admin_wr ? wr_data[{ADMIN_ID, 3'b0} +: 8] :
                    own_acc  ? wr_data[{owner_id, 3'b0} +: 8] : data_out;
  always_comb begin
    state_n = state;
    owner_n = owner_id;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    to_n    = 1'b0;
    if (state == IDLE) begin
      if (|lock_req) begin
        state_n = OWNED;
        owner_n = pick;
        cnt_n   = 8'd0;
      end
    end else if (unlock[owner_id]) begin
      state_n = IDLE;
      rr_n    = owner_id;
      cnt_n   = 8'd0;
    end else if (cnt == 8'(TIMEOUT - 1) && !own_acc) begin
      state_n = IDLE;
      rr_n    = owner_id;
      cnt_n   = 8'd0;
      to_n    = 1'b1;
    end else begin
      cnt_n = own_acc ? 8'd0 : cnt + 8'd1;
    end
  end
  always_comb begin
    locked   = state == OWNED;
    lock_gnt = locked ? 4'b0001 << owner_id : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= RESET_VAL;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      data_out <= data_n;
      wr_ack   <= admin_wr | own_acc;
      wr_err   <= |(wr_en & ~acc_mask);
    end
  end
endmodule
